score_display: RTL

Consumer of the 16-bit BCD score produced by the score counter. It tracks the session high score and latches the final score at game over. It drives a 4-digit multiplexed seven-segment display showing the live score, the final score, or the high score. It sits between the score counter and the board's display pins and shares game_start/game_over/game_tick with the counter.

---
 rtl/score_display.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
//
// Sits between the score counter and the board's 4-digit multiplexed
// seven-segment display. It tracks the session high score, latches the final
// score when a game ends, and scans the live, final or high score onto the
// display depending on the current mode:
//   IDLE : shows high_score
//   LIVE : shows the score input
//   HOLD : shows the latched final score for HOLD_TICKS game_tick pulses
//
// Parameters:
//   REFRESH_DIV : clk cycles each digit stays enabled before the scan moves on
//                 (must be >= 2)
//   HOLD_TICKS  : game_tick pulses the final score is held after game over
//                 (must be >= 1)
//
// Ports:
//   clk        : clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   score      : live BCD score, digit 3 in [15:12], digit 0 in [3:0]
//   game_start : single-cycle pulse, a game begins
//   game_over  : single-cycle pulse, the game ends
//   game_tick  : single-cycle 60 Hz frame pulse
//   seg        : active-high segments, bit order {g,f,e,d,c,b,a}
//   dig_en     : one-hot active-high digit enable, bit 0 = least-significant
//   high_score : BCD session high score
//   new_high   : the last finished game set a new high score
// -----------------------------------------------------------------------------
module score_display #(
    parameter int REFRESH_DIV = 1024,
    parameter int HOLD_TICKS  = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score,
    input  logic        game_start,
    input  logic        game_over,
    input  logic        game_tick,
    output logic [6:0]  seg,
    output logic [3:0]  dig_en,
    output logic [15:0] high_score,
    output logic        new_high
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LIVE = 2'd1,
        HOLD = 2'd2
    } mode_t;

    mode_t         mode;
    mode_t         mode_next;

    logic [15:0]   final_score;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;

    // Control strobes produced by the mode FSM and consumed by the datapath.
    logic          latch_final;
    logic          hold_inc;
    logic          hold_clear;
    logic          set_new_high;

    // Output-stage next values.
    logic [15:0]   shown;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    seg_next;
    logic [3:0]    dig_en_next;

    // BCD digit to gfedcba segments; non-decimal nibbles stay dark.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Mode FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking (<=) so every register samples
    // the pre-edge values of its sources, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= IDLE;
        end else begin
            mode <= mode_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        mode_next   = mode;
        latch_final = 1'b0;
        hold_inc    = 1'b0;
        hold_clear  = 1'b0;

        case (mode)
            LIVE: begin
                if (game_over) begin
                    mode_next   = HOLD;
                    latch_final = 1'b1;
                    hold_clear  = 1'b1;
                end
            end
            HOLD: begin
                if (game_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        mode_next  = IDLE;
                        hold_clear = 1'b1;
                    end else begin
                        hold_inc = 1'b1;
                    end
                end
            end
            default: begin
                // IDLE: game_over and game_tick have no effect.
            end
        endcase

        // A new game wins over anything else happening in the same cycle,
        // including a coincident game_over.
        if (game_start) begin
            mode_next   = LIVE;
            latch_final = 1'b0;
            hold_inc    = 1'b0;
            hold_clear  = 1'b0;
        end
    end

    // Plain unsigned compare orders BCD values correctly.
    assign set_new_high = latch_final && (score > high_score);

    // -------------------------------------------------------------------------
    // Score registers and hold counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_score  <= '0;
            final_score <= '0;
            new_high    <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            if (latch_final) begin
                final_score <= score;
            end

            if (set_new_high) begin
                high_score <= score;
            end

            if (game_start) begin
                new_high <= 1'b0;
            end else if (set_new_high) begin
                new_high <= 1'b1;
            end

            if (hold_clear) begin
                hold_cnt <= '0;
            end else if (hold_inc) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Digit scan: free-running in every mode
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else begin
            if (refresh_cnt == REFRESH_LAST) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output stage
    // -------------------------------------------------------------------------
    always_comb begin
        case (mode)
            LIVE:    shown = score;
            HOLD:    shown = final_score;
            default: shown = high_score;
        endcase
    end

    assign nibble = shown[{digit_idx, 2'b00} +: 4];

    // Digit k goes dark when it and every more-significant digit are zero;
    // digit 0 always lights so a zero value still shows a single "0".
    always_comb begin
        case (digit_idx)
            2'd1:    blank = (shown[15:4] == 12'h000);
            2'd2:    blank = (shown[15:8] == 8'h00);
            2'd3:    blank = (shown[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end

    assign seg_next    = blank ? 7'h00 : encode(nibble);
    assign dig_en_next = 4'b0001 << digit_idx;

    // seg and dig_en register together so segments never glitch onto the
    // wrong digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg    <= 7'h00;
            dig_en <= 4'b0001;
        end else begin
            seg    <= seg_next;
            dig_en <= dig_en_next;
        end
    end

endmodule
